// File: rtl/hdmi_rx_tmds_decoder.sv
// hdmi_rx_tmds_decoder: this block handles one TMDS channel on the receive side.
// It takes raw 10-bit words from the deserializer and finds the word boundary
// (a slip of 0..9 bits) by looking for runs of control tokens. It then decodes
// each aligned word into 8-bit video data or a 2-bit control value, tracks
// lock, and counts how many times lock has been lost.
module hdmi_rx_tmds_decoder #(
    parameter int TMDS_DATA_WIDTH = 10,
    parameter int CTRL_RUN        = 8,
    parameter int SEARCH_TIMEOUT  = 64,
    parameter int LOCK_TIMEOUT    = 4096
) (
    input  logic                       pix_clk_i,
    input  logic                       pix_rst_i,
    input  logic                       tmds_tvalid_i,
    input  logic [TMDS_DATA_WIDTH-1:0] tmds_tdata_i,
    input  logic                       resync_i,
    output logic                       vid_valid_o,
    output logic                       vid_de_o,
    output logic [7:0]                 vid_data_o,
    output logic [1:0]                 vid_ctrl_o,
    output logic                       locked_o,
    output logic [3:0]                 bit_offset_o,
    output logic [7:0]                 lock_loss_cnt_o
);

    localparam int W     = TMDS_DATA_WIDTH;
    localparam int RUN_W = $clog2(CTRL_RUN + 1);
    localparam int TMO_W = $clog2(SEARCH_TIMEOUT + 1);
    localparam int GAP_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Returns {is_token, ctrl[1:0]} for a word that is already aligned.
    function automatic logic [2:0] tok_decode(input logic [W-1:0] q);
        case (q)
            10'b1101010100: return 3'b100;
            10'b0010101011: return 3'b101;
            10'b0101010100: return 3'b110;
            10'b1010101011: return 3'b111;
            default:        return 3'b000;
        endcase
    endfunction

    // TMDS 10b->8b data decode. q[9] selects inversion and q[8] selects XOR or XNOR chaining.
    function automatic logic [7:0] data_decode(input logic [W-1:0] q);
        logic [7:0] b;
        logic [7:0] d;
        b    = q[9] ? ~q[7:0] : q[7:0];
        d[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        end
        return d;
    endfunction

    logic [0:0]     state, state_nxt;
    logic [RUN_W-1:0] run_cnt, run_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [3:0]     bit_offset, offset_nxt;
    logic [7:0]     loss_cnt, loss_nxt;

    logic [W-1:0]   prev;
    logic [2*W-1:0] window;
    logic [W-1:0]   aligned_s0;
    logic [2:0]     tok_s0;

    logic [W-1:0]   aligned_p1;
    logic           vld_p1;
    logic [2:0]     tok_p1;
    logic [7:0]     dat_p1;

    logic           vld_p2;
    logic           de_p2;
    logic [7:0]     data_p2;
    logic [1:0]     ctrl_p2;

    // ---- stage 0: slip window over the previous and current raw words ----
    assign window     = {tmds_tdata_i, prev};
    assign aligned_s0 = W'(window >> bit_offset);
    assign tok_s0     = tok_decode(aligned_s0);

    // Alignment and lock control. Only valid words advance the counters; resync wins over every other event.
    always_comb begin
        state_nxt  = state;
        run_nxt    = run_cnt;
        tmo_nxt    = tmo_cnt;
        gap_nxt    = gap_cnt;
        offset_nxt = bit_offset;
        loss_nxt   = loss_cnt;
        if (resync_i) begin
            state_nxt = ST_SEARCH;
            run_nxt   = '0;
            tmo_nxt   = '0;
            gap_nxt   = '0;
        end else if (tmds_tvalid_i) begin
            if (state == ST_SEARCH) begin
                tmo_nxt = tmo_cnt + 1'b1;
                run_nxt = tok_s0[2] ? run_cnt + 1'b1 : '0;
                if (tok_s0[2] && run_nxt == RUN_W'(CTRL_RUN)) begin
                    state_nxt = ST_LOCKED;
                    run_nxt   = '0;
                    tmo_nxt   = '0;
                    gap_nxt   = '0;
                end else if (tmo_nxt == TMO_W'(SEARCH_TIMEOUT)) begin
                    offset_nxt = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
                    run_nxt    = '0;
                    tmo_nxt    = '0;
                end
            end else begin
                gap_nxt = tok_s0[2] ? '0 : gap_cnt + 1'b1;
                if (gap_nxt == GAP_W'(LOCK_TIMEOUT)) begin
                    state_nxt = ST_SEARCH;
                    gap_nxt   = '0;
                    run_nxt   = '0;
                    tmo_nxt   = '0;
                    if (loss_cnt != 8'hFF) begin
                        loss_nxt = loss_cnt + 8'd1;
                    end
                end
            end
        end
    end

    // Register the control state.
    always_ff @(posedge pix_clk_i or posedge pix_rst_i) begin
        if (pix_rst_i) begin
            state      <= ST_SEARCH;
            run_cnt    <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            bit_offset <= '0;
            loss_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            run_cnt    <= run_nxt;
            tmo_cnt    <= tmo_nxt;
            gap_cnt    <= gap_nxt;
            bit_offset <= offset_nxt;
            loss_cnt   <= loss_nxt;
        end
    end

    // ---- stage 0 -> stage 1: capture history and the aligned word ----
    // Stage-1 valid marks only words that were accepted while already locked.
    always_ff @(posedge pix_clk_i or posedge pix_rst_i) begin
        if (pix_rst_i) begin
            prev       <= '0;
            aligned_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= tmds_tvalid_i && (state == ST_LOCKED);
            if (tmds_tvalid_i) begin
                prev       <= tmds_tdata_i;
                aligned_p1 <= aligned_s0;
            end
        end
    end

    assign tok_p1 = tok_decode(aligned_p1);
    assign dat_p1 = data_decode(aligned_p1);

    // ---- stage 1 -> stage 2: decode into the video outputs ----
    // Valid drops on the same edge as lock drops. Data and control values hold whenever nothing is output.
    always_ff @(posedge pix_clk_i or posedge pix_rst_i) begin
        if (pix_rst_i) begin
            vld_p2  <= 1'b0;
            de_p2   <= 1'b0;
            data_p2 <= '0;
            ctrl_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1 && (state_nxt == ST_LOCKED);
            if (vld_p1 && (state_nxt == ST_LOCKED)) begin
                if (tok_p1[2]) begin
                    de_p2   <= 1'b0;
                    data_p2 <= '0;
                    ctrl_p2 <= tok_p1[1:0];
                end else begin
                    de_p2   <= 1'b1;
                    data_p2 <= dat_p1;
                end
            end
        end
    end

    assign vid_valid_o     = vld_p2;
    assign vid_de_o        = de_p2;
    assign vid_data_o      = data_p2;
    assign vid_ctrl_o      = ctrl_p2;
    assign locked_o        = (state == ST_LOCKED);
    assign bit_offset_o    = bit_offset;
    assign lock_loss_cnt_o = loss_cnt;

endmodule
